// File: rtl/user_id_pkg.sv
// ---------------------------------------------------------------------------
// user_id_pkg
// Shared definitions for the user project ID serializer:
//   - state_t       : serializer FSM states
//   - USER_ID_WIDTH : default width of the user project ID word
//   - clk_div_legal : checks that a bit-period divider is usable
// ---------------------------------------------------------------------------
package user_id_pkg;

  localparam int USER_ID_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    PARITY,
    DONE
  } state_t;

  // The bit clock spends half of each bit period low and half high.
  // The divider therefore has to split evenly, and it needs at least one
  // cycle in each half.
  function automatic bit clk_div_legal(input int div);
    return (div >= 2) && ((div % 2) == 0);
  endfunction

endpackage

// File: rtl/user_id_bit_timer.sv
// ---------------------------------------------------------------------------
// user_id_bit_timer
// Counts clk cycles inside one serial bit period of CLK_DIV cycles.
// Ports:
//   clk       in  system clock
//   resetn    in  synchronous active-low reset
//   enable    in  count while high; counter is held at 0 while low
//   clear     in  force the counter back to 0 (transfer cancelled)
//   bit_end   out high on the last cycle of a bit period (only when enabled)
//   sck_phase out high during the second half of the bit period
// ---------------------------------------------------------------------------
module user_id_bit_timer
  import user_id_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic enable,
  input  logic clear,
  output logic bit_end,
  output logic sck_phase
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST_CYCLE = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_CYCLE = CW'(CLK_DIV / 2);

  // Refuse to elaborate with a divider that cannot give a symmetric sck.
  if (!clk_div_legal(CLK_DIV)) begin : g_bad_clk_div
    $error("user_id_bit_timer: CLK_DIV must be even and >= 2");
  end

  logic [CW-1:0] cycle_cnt;

  assign bit_end   = enable && (cycle_cnt == LAST_CYCLE);
  assign sck_phase = (cycle_cnt >= HALF_CYCLE);

  // The cycle counter restarts at every bit boundary, and sits at zero
  // whenever the serializer is not shifting, so every new bit period (and
  // every new transfer) begins with sck low.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cycle_cnt <= '0;
    end else if (clear || !enable || bit_end) begin
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/user_id_serializer.sv
// ---------------------------------------------------------------------------
// user_id_serializer
// Captures the user project ID on request, holds it on a parallel readback
// port and shifts it out as a framed serial stream followed by an even
// parity bit.
// Ports:
//   clk        in  system clock
//   resetn     in  synchronous active-low reset
//   mask_rev   in  [ID_WIDTH] user project ID from the ID programming block
//   start      in  request capture + serial transfer
//   abort      in  cancel the transfer in progress
//   busy       out high while a transfer is being processed
//   frame      out high while bit or parity data is on sdo
//   sck        out serial bit clock, high in the second half of a bit
//   sdo        out serial data
//   done       out one-cycle pulse at the end of a completed transfer
//   id_latched out [ID_WIDTH] last captured ID
//   id_valid   out set on first capture, sticky until reset
// ---------------------------------------------------------------------------
module user_id_serializer
  import user_id_pkg::*;
#(
  parameter int ID_WIDTH  = USER_ID_WIDTH,
  parameter int CLK_DIV   = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [ID_WIDTH-1:0] mask_rev,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                frame,
  output logic                sck,
  output logic                sdo,
  output logic                done,
  output logic [ID_WIDTH-1:0] id_latched,
  output logic                id_valid
);

  localparam int BCW = $clog2(ID_WIDTH + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(ID_WIDTH - 1);

  state_t              state;
  logic [ID_WIDTH-1:0] shift_reg;
  logic                parity_bit;
  logic [BCW-1:0]      bit_cnt;
  logic                head_bit;
  logic                timer_en;
  logic                timer_clear;
  logic                bit_end;
  logic                sck_phase;

  assign head_bit    = MSB_FIRST ? shift_reg[ID_WIDTH-1] : shift_reg[0];
  assign timer_en    = (state == SHIFT) || (state == PARITY);
  assign timer_clear = abort && (state != IDLE) && (state != DONE);

  user_id_bit_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_bit_timer (
    .clk       (clk),
    .resetn    (resetn),
    .enable    (timer_en),
    .clear     (timer_clear),
    .bit_end   (bit_end),
    .sck_phase (sck_phase)
  );

  // Serializer FSM with registered outputs. The outputs are decoded from the
  // state being left at each edge, so the pins trail the state by one cycle:
  // busy rises one cycle after LOAD is entered and the first bit appears one
  // cycle after SHIFT is entered. The abort path is the exception: it zeroes
  // the outputs at the same edge that returns to IDLE, so the pins go quiet
  // on the very next cycle. abort is ignored in DONE so a finished transfer
  // always gets its done pulse.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      bit_cnt    <= '0;
      busy       <= 1'b0;
      frame      <= 1'b0;
      sck        <= 1'b0;
      sdo        <= 1'b0;
      done       <= 1'b0;
      id_latched <= '0;
      id_valid   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          busy    <= 1'b0;
          frame   <= 1'b0;
          sck     <= 1'b0;
          sdo     <= 1'b0;
          bit_cnt <= '0;
          if (start && !abort) begin
            state <= LOAD;
          end
        end

        LOAD: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            shift_reg  <= mask_rev;
            id_latched <= mask_rev;
            id_valid   <= 1'b1;
            parity_bit <= ^mask_rev;
            bit_cnt    <= '0;
            busy       <= 1'b1;
            state      <= SHIFT;
          end
        end

        SHIFT: begin
          if (abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            frame   <= 1'b0;
            sck     <= 1'b0;
            sdo     <= 1'b0;
            bit_cnt <= '0;
          end else begin
            busy  <= 1'b1;
            frame <= 1'b1;
            sck   <= sck_phase;
            sdo   <= head_bit;
            if (bit_end) begin
              shift_reg <= MSB_FIRST ? (shift_reg << 1) : (shift_reg >> 1);
              if (bit_cnt == LAST_BIT) begin
                bit_cnt <= '0;
                state   <= PARITY;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
        end

        PARITY: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            frame <= 1'b0;
            sck   <= 1'b0;
            sdo   <= 1'b0;
          end else begin
            busy  <= 1'b1;
            frame <= 1'b1;
            sck   <= sck_phase;
            sdo   <= parity_bit;
            if (bit_end) begin
              state <= DONE;
            end
          end
        end

        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b1;
          frame <= 1'b0;
          sck   <= 1'b0;
          sdo   <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_user_id_serializer.sv
// ---------------------------------------------------------------------------
// tb_user_id_serializer
// Three serializers run side by side: CLK_DIV=4 MSB-first, CLK_DIV=4
// LSB-first and CLK_DIV=2 MSB-first. Each transfer is predicted from the
// ID value alone: the ordered bit list, the parity from a population count
// and the cycle position of every bit follow from the frame timing rules.
// ---------------------------------------------------------------------------
module tb_user_id_serializer;

  localparam int W = 32;
  localparam int N = 3;

  logic         clk = 1'b0;
  logic         resetn;
  logic [W-1:0] mask_rev;
  logic         start   [N];
  logic         abort   [N];
  logic         busy_w  [N];
  logic         frame_w [N];
  logic         sck_w   [N];
  logic         sdo_w   [N];
  logic         done_w  [N];
  logic [W-1:0] latched_w [N];
  logic         valid_w [N];

  logic [W-1:0] latched_exp [N];
  logic         valid_exp   [N];

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  user_id_serializer #(.ID_WIDTH(W), .CLK_DIV(4), .MSB_FIRST(1'b1)) dut_msb4 (
    .clk(clk), .resetn(resetn), .mask_rev(mask_rev),
    .start(start[0]), .abort(abort[0]),
    .busy(busy_w[0]), .frame(frame_w[0]), .sck(sck_w[0]), .sdo(sdo_w[0]),
    .done(done_w[0]), .id_latched(latched_w[0]), .id_valid(valid_w[0])
  );

  user_id_serializer #(.ID_WIDTH(W), .CLK_DIV(4), .MSB_FIRST(1'b0)) dut_lsb4 (
    .clk(clk), .resetn(resetn), .mask_rev(mask_rev),
    .start(start[1]), .abort(abort[1]),
    .busy(busy_w[1]), .frame(frame_w[1]), .sck(sck_w[1]), .sdo(sdo_w[1]),
    .done(done_w[1]), .id_latched(latched_w[1]), .id_valid(valid_w[1])
  );

  user_id_serializer #(.ID_WIDTH(W), .CLK_DIV(2), .MSB_FIRST(1'b1)) dut_msb2 (
    .clk(clk), .resetn(resetn), .mask_rev(mask_rev),
    .start(start[2]), .abort(abort[2]),
    .busy(busy_w[2]), .frame(frame_w[2]), .sck(sck_w[2]), .sdo(sdo_w[2]),
    .done(done_w[2]), .id_latched(latched_w[2]), .id_valid(valid_w[2])
  );

  function automatic int div_of(input int inst);
    return (inst == 2) ? 2 : 4;
  endfunction

  function automatic bit msb_of(input int inst);
    return (inst != 1);
  endfunction

  // {busy, frame, sck, sdo, done} of one instance
  function automatic logic [4:0] ctrl_of(input int inst);
    return {busy_w[inst], frame_w[inst], sck_w[inst], sdo_w[inst], done_w[inst]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [W-1:0] obs,
                              input logic [W-1:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Quiet pins plus the sticky readback the bench expects for this instance.
  task automatic check_idle(input int inst, input string tag);
    check_output({tag, " ctrl"}, W'(ctrl_of(inst)), '0);
    check_output({tag, " id_latched"}, latched_w[inst], latched_exp[inst]);
    check_output({tag, " id_valid"}, W'(valid_w[inst]), W'(valid_exp[inst]));
  endtask

  // One transfer on one instance. abort_at / reset_at give the frame cycle
  // (0 = first data cycle) at which abort or resetn is applied, -1 for none.
  // poke also raises start mid-shift and start+abort during DONE.
  task automatic apply_stimulus(input int inst, input logic [W-1:0] id,
                                input int abort_at, input int reset_at,
                                input bit poke);
    int   div;
    int   frame_len;
    int   bit_idx;
    int   phase;
    bit   par;
    bit   stream[$];
    logic exp_sdo;
    logic exp_sck;

    div       = div_of(inst);
    frame_len = (W + 1) * div;
    par       = ($countones(id) % 2) != 0;
    for (int k = 0; k < W; k++) begin
      stream.push_back(msb_of(inst) ? id[W-1-k] : id[k]);
    end
    stream.push_back(par);

    mask_rev    = id;
    start[inst] = 1'b1;
    tick();
    start[inst] = 1'b0;
    tick();
    latched_exp[inst] = id;
    valid_exp[inst]   = 1'b1;
    check_output("load ctrl", W'(ctrl_of(inst)), W'(5'b10000));
    check_output("load id_latched", latched_w[inst], id);
    check_output("load id_valid", W'(valid_w[inst]), 1);
    mask_rev = $urandom;

    for (int i = 0; i < frame_len; i++) begin
      if (i == abort_at) abort[inst] = 1'b1;
      if (i == reset_at) resetn = 1'b0;
      if (poke && i == 20) start[inst] = 1'b1;
      tick();
      abort[inst] = 1'b0;
      start[inst] = 1'b0;
      if (i == reset_at) begin
        resetn = 1'b1;
        for (int j = 0; j < N; j++) begin
          latched_exp[j] = '0;
          valid_exp[j]   = 1'b0;
          check_idle(j, "reset");
        end
        return;
      end
      if (i == abort_at) begin
        check_idle(inst, "abort");
        for (int j = 0; j < 3 * div; j++) begin
          tick();
          check_output("abort no done", W'(ctrl_of(inst)), '0);
        end
        check_idle(inst, "abort later");
        return;
      end
      bit_idx = i / div;
      phase   = i % div;
      exp_sdo = stream[bit_idx];
      exp_sck = (phase >= div / 2);
      check_output("frame bit", W'(ctrl_of(inst)),
                   W'({1'b1, 1'b1, exp_sck, exp_sdo, 1'b0}));
    end

    if (poke) begin
      start[inst] = 1'b1;
      abort[inst] = 1'b1;
    end
    tick();
    start[inst] = 1'b0;
    abort[inst] = 1'b0;
    check_output("done pulse", W'(ctrl_of(inst)), W'(5'b10001));
    tick();
    check_idle(inst, "after done");
    if (poke) begin
      tick();
      check_idle(inst, "no queued start");
    end
    check_output("id_latched kept", latched_w[inst], id);
  endtask

  initial begin
    resetn   = 1'b0;
    mask_rev = '0;
    for (int j = 0; j < N; j++) begin
      start[j]       = 1'b0;
      abort[j]       = 1'b0;
      latched_exp[j] = '0;
      valid_exp[j]   = 1'b0;
    end
    tick();
    tick();
    for (int j = 0; j < N; j++) check_idle(j, "reset state");
    resetn = 1'b1;
    tick();
    for (int j = 0; j < N; j++) check_idle(j, "post reset");

    $display("[TB] baseline MSB-first transfer");
    apply_stimulus(0, 32'hA5A5_0F01, -1, -1, 1'b0);

    $display("[TB] LSB-first transfer");
    apply_stimulus(1, 32'h0000_0001, -1, -1, 1'b0);

    $display("[TB] CLK_DIV=2 sweep");
    apply_stimulus(2, 32'hFFFF_FFFF, -1, -1, 1'b0);

    $display("[TB] abort at bit 10 then restart");
    apply_stimulus(0, 32'h1234_5678, 10 * 4 + 1, -1, 1'b0);
    apply_stimulus(0, 32'h9ABC_DEF0, -1, -1, 1'b0);

    $display("[TB] start+abort in IDLE");
    start[0] = 1'b1;
    abort[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    abort[0] = 1'b0;
    tick();
    check_idle(0, "start+abort idle");
    tick();
    check_idle(0, "start+abort idle 2");

    $display("[TB] start during SHIFT and DONE, abort during DONE");
    apply_stimulus(0, 32'hC3C3_5AA5, -1, -1, 1'b1);

    $display("[TB] reset during PARITY then full frame");
    apply_stimulus(0, 32'h0F0F_1357, -1, W * 4 + 1, 1'b0);
    apply_stimulus(0, 32'hDEAD_BEEF, -1, -1, 1'b0);

    $display("[TB] random transfers");
    for (int r = 0; r < 6; r++) begin
      int inst;
      int ab;
      inst = $urandom_range(0, N - 1);
      ab   = ($urandom_range(0, 2) == 0) ?
             $urandom_range(0, (W + 1) * div_of(inst) - 1) : -1;
      apply_stimulus(inst, $urandom, ab, -1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
